// File: rtl/readout_seq_pkg.sv
// Shared types and derived sizes for the readout shot sequencer.
package readout_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    function automatic int ncls(input int pred_bits);
        return 1 << pred_bits;
    endfunction

    function automatic int timer_bits(input int timeout_cycles);
        return $clog2(timeout_cycles);
    endfunction

endpackage

// File: rtl/readout_shot_sequencer_if.sv
// Config, trigger, classifier and result-BRAM signals of the shot sequencer.
interface readout_shot_sequencer_if
    import readout_seq_pkg::*;
#(
    parameter int PRED_BITS      = 2,
    parameter int BRAM_ADDR_BITS = 14,
    parameter int CNT_W          = 16
);
    localparam int NCLS = ncls(PRED_BITS);

    logic                        cfg_start;
    logic                        cfg_abort;
    logic [BRAM_ADDR_BITS:0]     cfg_num_shots;
    logic [BRAM_ADDR_BITS-1:0]   cfg_base_addr;
    logic                        qick_trigger;
    logic                        cls_trigger;
    logic                        cls_we;
    logic [PRED_BITS-1:0]        cls_data;
    logic [BRAM_ADDR_BITS-1:0]   bram_addr;
    logic [PRED_BITS-1:0]        bram_data;
    logic                        bram_we;
    logic                        busy;
    logic                        done;
    logic                        timeout_err;
    logic [CNT_W-1:0]            overrun_cnt;
    logic [NCLS*CNT_W-1:0]       class_cnt;

    modport master (
        output cfg_start, cfg_abort, cfg_num_shots, cfg_base_addr,
        output qick_trigger, cls_we, cls_data,
        input  cls_trigger, bram_addr, bram_data, bram_we,
        input  busy, done, timeout_err, overrun_cnt, class_cnt
    );

    modport slave (
        input  cfg_start, cfg_abort, cfg_num_shots, cfg_base_addr,
        input  qick_trigger, cls_we, cls_data,
        output cls_trigger, bram_addr, bram_data, bram_we,
        output busy, done, timeout_err, overrun_cnt, class_cnt
    );

endinterface

// File: rtl/readout_shot_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module seq_sat_counter #(
    parameter int W = 16
) (
    input  logic         ap_clk,
    input  logic         ap_rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q, q_d;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) q_q <= '0;
        else           q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/readout_shot_sequencer.sv
// Run controller: forwards one trigger per shot, re-addresses predictions into BRAM, keeps histograms.
module readout_shot_sequencer
    import readout_seq_pkg::*;
#(
    parameter int PRED_BITS      = 2,
    parameter int BRAM_ADDR_BITS = 14,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    readout_shot_sequencer_if.slave bus
);
    localparam int NCLS = ncls(PRED_BITS);
    localparam int TW   = timer_bits(TIMEOUT_CYCLES);
    localparam int AW   = BRAM_ADDR_BITS;

    seq_state_e           state_q, state_d;
    logic [AW:0]          num_shots_q, num_shots_d;
    logic [AW:0]          shot_idx_q, shot_idx_d;
    logic [AW-1:0]        base_q, base_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 cls_trig_q, cls_trig_d;
    logic                 bram_we_q, bram_we_d;
    logic [AW-1:0]        bram_addr_q, bram_addr_d;
    logic [PRED_BITS-1:0] bram_data_q, bram_data_d;
    logic                 done_q, done_d;
    logic                 timeout_q, timeout_d;
    logic                 cnt_clr;
    logic                 ovr_inc;
    logic [NCLS-1:0]      cls_inc;
    logic [NCLS*CNT_W-1:0] class_cnt_w;
    logic [CNT_W-1:0]     overrun_w;

    always_comb begin
        state_d     = state_q;
        num_shots_d = num_shots_q;
        shot_idx_d  = shot_idx_q;
        base_d      = base_q;
        timer_d     = timer_q;
        cls_trig_d  = 1'b0;
        bram_we_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        bram_data_d = bram_data_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        cnt_clr     = 1'b0;
        ovr_inc     = 1'b0;
        cls_inc     = '0;

        // Abort outranks every other event, including a same-cycle start.
        if (bus.cfg_abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.cfg_start) begin
                        num_shots_d = bus.cfg_num_shots;
                        base_d      = bus.cfg_base_addr;
                        shot_idx_d  = '0;
                        timeout_d   = 1'b0;
                        cnt_clr     = 1'b1;
                        done_d      = (bus.cfg_num_shots == '0);
                        state_d     = (bus.cfg_num_shots == '0) ? DONE : ARMED;
                    end
                end
                ARMED: begin
                    if (bus.qick_trigger) begin
                        cls_trig_d = 1'b1;
                        timer_d    = '0;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    ovr_inc = bus.qick_trigger;
                    timer_d = timer_q + 1'b1;
                    if (bus.cls_we) begin
                        bram_we_d   = 1'b1;
                        bram_addr_d = base_q + shot_idx_q[AW-1:0];
                        bram_data_d = bus.cls_data;
                        cls_inc[bus.cls_data] = 1'b1;
                        shot_idx_d  = shot_idx_q + 1'b1;
                        if (shot_idx_d == num_shots_q) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = ARMED;
                        end
                    end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            num_shots_q <= '0;
            shot_idx_q  <= '0;
            base_q      <= '0;
            timer_q     <= '0;
            cls_trig_q  <= 1'b0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_data_q <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_shots_q <= num_shots_d;
            shot_idx_q  <= shot_idx_d;
            base_q      <= base_d;
            timer_q     <= timer_d;
            cls_trig_q  <= cls_trig_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_data_q <= bram_data_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    for (genvar k = 0; k < NCLS; k++) begin : g_class_cnt
        seq_sat_counter #(.W(CNT_W)) u_cnt (
            .ap_clk   (ap_clk),
            .ap_rst_n (ap_rst_n),
            .inc      (cls_inc[k]),
            .clr      (cnt_clr),
            .q        (class_cnt_w[k*CNT_W +: CNT_W])
        );
    end

    seq_sat_counter #(.W(CNT_W)) u_overrun_cnt (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .inc      (ovr_inc),
        .clr      (cnt_clr),
        .q        (overrun_w)
    );

    assign bus.cls_trigger = cls_trig_q;
    assign bus.bram_we     = bram_we_q;
    assign bus.bram_addr   = bram_addr_q;
    assign bus.bram_data   = bram_data_q;
    assign bus.busy        = (state_q == ARMED) || (state_q == WAIT);
    assign bus.done        = done_q;
    assign bus.timeout_err = timeout_q;
    assign bus.overrun_cnt = overrun_w;
    assign bus.class_cnt   = class_cnt_w;

endmodule

// File: tb/tb_readout_shot_sequencer.sv
// Directed scenarios plus randomized traffic, every cycle compared against a shot-level reference model.
module tb_readout_shot_sequencer;
    localparam int PB  = 2;
    localparam int AW  = 14;
    localparam int CW  = 2;
    localparam int TO  = 16;
    localparam int NC  = 4;
    localparam int SAT = (1 << CW) - 1;
    localparam int AMOD = 1 << AW;

    localparam int M_IDLE = 0, M_ARMED = 1, M_WAIT = 2, M_DONE = 3;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    readout_shot_sequencer_if #(.PRED_BITS(PB), .BRAM_ADDR_BITS(AW), .CNT_W(CW)) bus ();

    readout_shot_sequencer #(
        .PRED_BITS(PB), .BRAM_ADDR_BITS(AW), .CNT_W(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: run phase, shot bookkeeping and expected outputs after each edge.
    int m_mode, m_n, m_base, m_idx, m_trig_cyc, m_ovr;
    int m_hist [NC];
    bit e_trig, e_we, e_done, e_to;
    int e_addr, e_data;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_mode = M_IDLE; m_n = 0; m_base = 0; m_idx = 0; m_trig_cyc = 0; m_ovr = 0;
        for (int k = 0; k < NC; k++) m_hist[k] = 0;
        e_trig = 0; e_we = 0; e_done = 0; e_to = 0; e_addr = 0; e_data = 0;
    endfunction

    function automatic void model_step(input bit st, input bit ab, input bit qk, input bit we,
                                       input int d, input int n, input int base);
        e_trig = 0;
        e_we   = 0;
        if (ab) begin
            m_mode = M_IDLE;
            return;
        end
        if (m_mode == M_IDLE || m_mode == M_DONE) begin
            if (st) begin
                m_n = n; m_base = base; m_idx = 0; m_ovr = 0;
                for (int k = 0; k < NC; k++) m_hist[k] = 0;
                e_to   = 0;
                e_done = (n == 0);
                m_mode = (n == 0) ? M_DONE : M_ARMED;
            end
        end else if (m_mode == M_ARMED) begin
            if (qk) begin
                e_trig     = 1;
                m_trig_cyc = cyc + 1;
                m_mode     = M_WAIT;
            end
        end else begin
            if (qk && m_ovr < SAT) m_ovr++;
            if (we) begin
                e_we   = 1;
                e_addr = (m_base + m_idx) % AMOD;
                e_data = d;
                if (m_hist[d] < SAT) m_hist[d]++;
                m_idx++;
                if (m_idx == m_n) begin
                    e_done = 1;
                    m_mode = M_DONE;
                end else begin
                    m_mode = M_ARMED;
                end
            end else if ((cyc + 1) - m_trig_cyc == TO) begin
                e_to   = 1;
                e_done = 1;
                m_mode = M_DONE;
            end
        end
    endfunction

    task automatic compare_all();
        logic [63:0] hv;
        hv = '0;
        for (int k = 0; k < NC; k++) hv[k*CW +: CW] = CW'(m_hist[k]);
        check("cls_trigger", 64'(bus.cls_trigger), 64'(e_trig));
        check("bram_we", 64'(bus.bram_we), 64'(e_we));
        if (e_we) begin
            check("bram_addr", 64'(bus.bram_addr), 64'(e_addr));
            check("bram_data", 64'(bus.bram_data), 64'(e_data));
        end
        check("busy", 64'(bus.busy), 64'(m_mode == M_ARMED || m_mode == M_WAIT));
        check("done", 64'(bus.done), 64'(e_done));
        check("timeout_err", 64'(bus.timeout_err), 64'(e_to));
        check("overrun_cnt", 64'(bus.overrun_cnt), 64'(m_ovr));
        check("class_cnt", 64'(bus.class_cnt), hv);
    endtask

    task automatic step(input bit st, input bit ab, input bit qk, input bit we, input int d);
        bus.cfg_start    = st;
        bus.cfg_abort    = ab;
        bus.qick_trigger = qk;
        bus.cls_we       = we;
        bus.cls_data     = PB'(d);
        model_step(st, ab, qk, we, d, int'(bus.cfg_num_shots), int'(bus.cfg_base_addr));
        @(posedge ap_clk);
        @(negedge ap_clk);
        cyc++;
        compare_all();
    endtask

    initial begin
        logic [7:0] cc;
        bus.cfg_start = 0; bus.cfg_abort = 0; bus.qick_trigger = 0; bus.cls_we = 0;
        bus.cls_data = '0; bus.cfg_num_shots = '0; bus.cfg_base_addr = '0;
        model_reset();
        @(negedge ap_clk);
        compare_all();
        ap_rst_n = 1'b1;

        // Three-shot run with address wrap and two overruns during shot 0.
        bus.cfg_num_shots = 15'd3;
        bus.cfg_base_addr = 14'h3FFE;
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1);
        check("shot0_addr", 64'(bus.bram_addr), 64'h3FFE);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 2);
        check("shot1_addr", 64'(bus.bram_addr), 64'h3FFF);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1);
        check("shot2_addr_wrap", 64'(bus.bram_addr), 64'h0);
        check("run3_done", 64'(bus.done), 64'd1);
        check("run3_busy", 64'(bus.busy), 64'd0);
        check("run3_hist", 64'(bus.class_cnt), 64'h18);
        check("run3_overrun", 64'(bus.overrun_cnt), 64'd2);
        step(0, 0, 0, 1, 3);

        // Timeout: no classifier result after the trigger.
        bus.cfg_num_shots = 15'd1;
        bus.cfg_base_addr = 14'h100;
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0, 0);
        check("timeout_early", 64'(bus.timeout_err), 64'd0);
        step(0, 0, 0, 0, 0);
        check("timeout_at_limit", 64'(bus.timeout_err), 64'd1);
        check("timeout_done", 64'(bus.done), 64'd1);
        step(1, 0, 0, 0, 0);
        check("start_clears_timeout", 64'(bus.timeout_err), 64'd0);
        check("start_clears_done", 64'(bus.done), 64'd0);

        // Abort during WAIT; a later result is ignored.
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        step(0, 0, 0, 1, 2);
        check("abort_no_write", 64'(bus.bram_we), 64'd0);

        // Zero-shot run finishes immediately without a trigger.
        bus.cfg_num_shots = 15'd0;
        step(1, 0, 0, 0, 0);
        check("zero_shots_done", 64'(bus.done), 64'd1);
        step(0, 0, 1, 0, 0);
        check("zero_shots_no_trig", 64'(bus.cls_trigger), 64'd0);

        // Result while ARMED is ignored.
        bus.cfg_num_shots = 15'd2;
        bus.cfg_base_addr = 14'd5;
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 3);
        check("armed_we_ignored", 64'(bus.bram_we), 64'd0);
        check("armed_hist_clear", 64'(bus.class_cnt), 64'd0);

        // Saturation of a 2-bit histogram bin.
        step(0, 1, 0, 0, 0);
        bus.cfg_num_shots = 15'd5;
        bus.cfg_base_addr = 14'd0;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, 0);
            step(0, 0, 0, 1, 3);
        end
        cc = bus.class_cnt;
        check("sat_class3", 64'(cc[7:6]), 64'd3);

        // Asynchronous reset in the middle of WAIT.
        bus.cfg_num_shots = 15'd2;
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        #1 ap_rst_n = 1'b0;
        bus.qick_trigger = 0;
        #1;
        model_reset();
        check("rst_cls_trigger", 64'(bus.cls_trigger), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_class_cnt", 64'(bus.class_cnt), 64'd0);
        check("rst_overrun", 64'(bus.overrun_cnt), 64'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        compare_all();

        // Randomized traffic, alternating slow-classifier and normal segments.
        for (int seg = 0; seg < 20; seg++) begin
            int p_we;
            p_we = (seg % 3 == 0) ? 3 : 35;
            for (int i = 0; i < 150; i++) begin
                bus.cfg_num_shots = ($urandom_range(0, 7) == 0) ? 15'd0 : 15'($urandom_range(1, 5));
                bus.cfg_base_addr = ($urandom_range(0, 1) == 1) ? 14'($urandom)
                                                                : 14'(AMOD - int'($urandom_range(1, 3)));
                step($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 2,
                     $urandom_range(0, 99) < 30, $urandom_range(0, 99) < p_we,
                     int'($urandom_range(0, 3)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/readout_shot_sequencer.md
# readout_shot_sequencer

Run controller for the NN readout classifier. Software arms a run of N shots. For each shot, the block forwards one tProcessor trigger to the classifier, then waits for the classifier's prediction write. It re-addresses that prediction into a software-chosen BRAM region and keeps per-class histograms, overrun counts and a timeout flag. It sits between the tProcessor trigger and config registers on one side, and the classifier's trigger input and BRAM write port on the other.

## Interface
- PRED_BITS, 2, prediction width; number of classes is NCLS = 2**PRED_BITS
- BRAM_ADDR_BITS, 14, result BRAM address width
- CNT_W, 16, width of each histogram counter and the overrun counter
- TIMEOUT_CYCLES, 1024, maximum cycles from cls_trigger to cls_we; must be ≥ 2
- ap_clk  in  1  clock; all logic is on rising edge
- ap_rst_n  in  1  reset; asynchronous and active-low
- cfg_start  in  1  one-cycle pulse that arms a run
- cfg_abort  in  1  one-cycle pulse that kills the run
- cfg_num_shots  in  BRAM_ADDR_BITS+1  shots per run; sampled on cfg_start
- cfg_base_addr  in  BRAM_ADDR_BITS  first result address; sampled on cfg_start
- qick_trigger  in  1  shot trigger from the tProcessor
- cls_trigger  out  1  one-cycle trigger pulse to the classifier
- cls_we  in  1  classifier result-valid strobe
- cls_data  in  PRED_BITS  classifier prediction, valid when cls_we=1
- bram_addr  out  BRAM_ADDR_BITS  result write address
- bram_data  out  PRED_BITS  result write data
- bram_we  out  1  result write enable
- busy  out  1  high while in ARMED or WAIT
- done  out  1  sticky; set when a run ends; cleared by cfg_start
- timeout_err  out  1  sticky; cleared by cfg_start
- overrun_cnt  out  CNT_W  saturating count of triggers dropped while in WAIT
- class_cnt  out  NCLS*CNT_W  saturating histogram; class k occupies [k*CNT_W +: CNT_W]

## Operation
- States:
  - IDLE: reset state.
  - ARMED: waiting for a trigger.
  - WAIT: classifier running.
  - DONE: run finished.
- cfg_start in IDLE or DONE:
  - Latch num_shots and base_addr.
  - Clear shot_idx, class_cnt, overrun_cnt, done and timeout_err.
  - If num_shots == 0, go to DONE with done=1. Otherwise go to ARMED.
  - cfg_start in ARMED or WAIT is ignored.
- ARMED + qick_trigger: pulse cls_trigger, clear the timer, go to WAIT.
- WAIT + qick_trigger: drop the trigger (no cls_trigger) and increment overrun_cnt.
- WAIT + cls_we:
  - Write: bram_we=1, bram_addr=(base_addr+shot_idx) mod 2**BRAM_ADDR_BITS, bram_data=cls_data.
  - Increment class_cnt[cls_data] and shot_idx.
  - If shot_idx+1 == num_shots, go to DONE with done=1. Otherwise go to ARMED.
- WAIT with the timer at TIMEOUT_CYCLES-1 and no cls_we:
  - Set timeout_err=1 and done=1, go to DONE.
  - No BRAM write. shot_idx is unchanged.
- cls_we in IDLE, ARMED or DONE is ignored; no write occurs.
- cfg_abort in any state:
  - Go to IDLE. cls_trigger and bram_we are 0 in the following cycle.
  - Counters and flags hold their values; done is not set.
- All counters saturate at all-ones and never wrap. Address arithmetic does wrap: it is modular.

## Timing
- Reset values: every output is 0, state is IDLE.
- qick_trigger sampled at cycle t → cls_trigger high at t+1 for exactly one cycle. busy stays high.
- cls_we sampled at cycle t → bram_we, bram_addr, bram_data, the class_cnt update and the next state all take effect at t+1. For the last shot, done=1 and busy=0 also at t+1.
- Timeout is measured from the cls_trigger cycle. With cls_trigger at t and no cls_we, timeout_err rises at t+TIMEOUT_CYCLES.
- Simultaneous events:
  - cls_we and timeout in the same cycle: cls_we wins and there is no error.
  - cfg_abort and any other event: abort wins.
  - cfg_start and cfg_abort: abort wins.
  - qick_trigger and cls_we in WAIT: the trigger counts as an overrun and the result is written.
- A new trigger is accepted no earlier than the cycle after the ARMED state is entered. The return path is therefore cls_we at t → ARMED at t+1 → earliest qick_trigger sampled at t+1.
- Asserting ap_rst_n low mid-run clears all state immediately and asynchronously. A write in flight is lost.

## Structure
- Package readout_seq_pkg:
  - State enum (IDLE, ARMED, WAIT, DONE).
  - NCLS derivation.
  - Timer width: $clog2(TIMEOUT_CYCLES).
- Sub-module seq_sat_counter (parameter W; ports inc, clr, q):
  - Instantiated NCLS times for class_cnt and once for overrun_cnt.
  - Asynchronous active-low reset on ap_rst_n.
- The top level holds the FSM, the shot and address registers, the timer and the registered BRAM outputs.

## Test plan
- **Three-shot run.** cfg_num_shots=3, base=0x3FFE; classifier returns 1, 2, 1 → writes at 0x3FFE, 0x3FFF, 0x0000 (wrap). Final class_cnt is {0,2,1,0} for classes 0–3. done=1, busy=0 one cycle after the third cls_we.
- **Overrun.** Two extra qick_trigger pulses during WAIT of shot 0 → overrun_cnt=2. Exactly one cls_trigger is seen per shot.
- **Timeout.** TIMEOUT_CYCLES=16, cls_we never asserted → timeout_err=1 and done=1 exactly 16 cycles after cls_trigger. No bram_we. Then cfg_start clears both flags.
- **Boundaries.** cfg_num_shots=0 → done=1 one cycle after cfg_start, with no cls_trigger. cls_we in ARMED → no bram_we and class_cnt unchanged.
- **Abort and reset.** cfg_abort during WAIT → IDLE next cycle; a later cls_we is ignored. Asserting ap_rst_n low mid-WAIT clears all outputs to 0 asynchronously.
- **Saturation.** CNT_W=2 with 5 results of class 3 → class_cnt[3]=3, holding at saturation.
